// File: rtl/accel_pkg.sv
// rtl/accel_pkg.sv - shared FSM states, MMIO offsets and status bit positions for accel_dispatch
package accel_pkg;

  // FSM state encoding
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_FETCH  = 3'd1;
  localparam state_t S_HASH   = 3'd2;
  localparam state_t S_WRITE  = 3'd3;
  localparam state_t S_STATUS = 3'd4;

  // Word offsets inside the command window
  localparam logic [1:0] OFF_SRC = 2'd0;
  localparam logic [1:0] OFF_DST = 2'd1;
  localparam logic [1:0] OFF_GO  = 2'd2;

  // Bit positions inside the status word
  localparam int ST_DONE = 0;
  localparam int ST_OVR  = 1;
  localparam int ST_TO   = 2;

  localparam int DIGEST_WORDS = 8;

endpackage

// File: rtl/accel_digest_ser.sv
// rtl/accel_digest_ser.sv - latches a 256-bit digest and presents it one 32-bit word at a time
module accel_digest_ser
  import accel_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [255:0] digest,
  input  logic         advance,
  output logic [31:0]  word,
  output logic [2:0]   idx,
  output logic         last
);

  logic [255:0] dig_q;

  // Capture the digest on load and step the word index while advancing
  always_ff @(posedge clk) begin
    if (rst_n) begin
      dig_q <= '0;
      idx   <= '0;
    end else if (load) begin
      dig_q <= digest;
      idx   <= '0;
    end else if (advance) begin
      idx <= idx + 3'd1;
    end
  end

  // Word 0 lives in the most significant 32 bits
  assign word = dig_q[{3'(DIGEST_WORDS - 1) - idx, 5'd0} +: 32];
  assign last = (idx == 3'(DIGEST_WORDS - 1));

endmodule

// File: rtl/accel_dispatch.sv
// rtl/accel_dispatch.sv - MMIO job dispatcher feeding a SHA-256 core; ACCEL_TIMEOUT_EN enables the hash watchdog
module accel_dispatch
  import accel_pkg::*;
#(
  parameter logic [15:0] MMIO_BASE      = 16'hFF00,
  parameter int          RD_LAT         = 1,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cpu_wrt_en,
  input  logic [31:0]  cpu_wrt_data,
  input  logic [15:0]  cpu_addr,
  input  logic [511:0] accel_rd_data,
  output logic [15:0]  accel_addr,
  output logic         accel_wrt_en,
  output logic [31:0]  accel_wrt_data,
  output logic         hash_start,
  output logic [511:0] hash_block,
  input  logic         hash_done,
  input  logic [255:0] hash_digest,
  output logic         busy,
  output logic         done
);

  state_t      state;
  logic [15:0] src_reg, dst_reg, job_src, job_dst;
  logic [1:0]  fetch_cnt;
  logic        overrun, timeout, hash_first;
  logic        sel_src, sel_dst, go;
  logic        fetch_last, hash_fire, hash_expire;
  logic [31:0] ser_word;
  logic [2:0]  ser_idx;
  logic        ser_last;
  logic [31:0] status_word;
  logic        unused_wdata;

  assign sel_src = cpu_wrt_en && (cpu_addr == MMIO_BASE + 16'(OFF_SRC));
  assign sel_dst = cpu_wrt_en && (cpu_addr == MMIO_BASE + 16'(OFF_DST));
  assign go      = cpu_wrt_en && (cpu_addr == MMIO_BASE + 16'(OFF_GO)) && cpu_wrt_data[0];
  assign unused_wdata = ^cpu_wrt_data[31:16];

  assign fetch_last = (fetch_cnt == 2'(RD_LAT - 1));
  assign hash_fire  = (state == S_HASH) && hash_done;

`ifdef ACCEL_TIMEOUT_EN
  logic [15:0] hash_cnt;

  // Watchdog counts HASH cycles and restarts whenever the FSM is elsewhere
  always_ff @(posedge clk) begin
    if (rst_n || state != S_HASH) hash_cnt <= '0;
    else                          hash_cnt <= hash_cnt + 16'd1;
  end

  // A digest arriving in the final allowed cycle still wins over the timeout
  assign hash_expire = (state == S_HASH) && !hash_done &&
                       (hash_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
  logic [15:0] unused_timeout;
  assign unused_timeout = 16'(TIMEOUT_CYCLES);
  assign hash_expire    = 1'b0;
`endif

  // Command registers, job sequencing and sticky overrun tracking
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state      <= S_IDLE;
      src_reg    <= '0;
      dst_reg    <= '0;
      job_src    <= '0;
      job_dst    <= '0;
      fetch_cnt  <= '0;
      overrun    <= 1'b0;
      timeout    <= 1'b0;
      hash_first <= 1'b0;
      hash_block <= '0;
    end else begin
      if (sel_src) src_reg <= cpu_wrt_data[15:0];
      if (sel_dst) dst_reg <= cpu_wrt_data[15:0];
      hash_first <= 1'b0;

      // GO outside IDLE is rejected; a GO in the STATUS cycle survives the clear
      if (go && state != S_IDLE) overrun <= 1'b1;
      else if (state == S_STATUS) overrun <= 1'b0;

      case (state)
        S_IDLE: begin
          if (go) begin
            job_src   <= src_reg;
            job_dst   <= dst_reg;
            fetch_cnt <= '0;
            timeout   <= 1'b0;
            state     <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (fetch_last) begin
            hash_block <= accel_rd_data;
            hash_first <= 1'b1;
            state      <= S_HASH;
          end else begin
            fetch_cnt <= fetch_cnt + 2'd1;
          end
        end
        S_HASH: begin
          if (hash_done) begin
            state <= S_WRITE;
          end else if (hash_expire) begin
            timeout <= 1'b1;
            state   <= S_STATUS;
          end
        end
        S_WRITE:  if (ser_last) state <= S_STATUS;
        S_STATUS: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  accel_digest_ser u_ser (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (hash_fire),
    .digest  (hash_digest),
    .advance (state == S_WRITE),
    .word    (ser_word),
    .idx     (ser_idx),
    .last    (ser_last)
  );

  // Status word reported at the end of every job
  always_comb begin
    status_word          = '0;
    status_word[ST_DONE] = 1'b1;
    status_word[ST_OVR]  = overrun;
    status_word[ST_TO]   = timeout;
  end

  // Memory port drive: fetch address, digest writeback, then status
  always_comb begin
    accel_addr     = '0;
    accel_wrt_en   = 1'b0;
    accel_wrt_data = '0;
    done           = 1'b0;
    case (state)
      S_FETCH: accel_addr = job_src;
      S_WRITE: begin
        accel_wrt_en   = 1'b1;
        accel_addr     = job_dst + 16'(ser_idx);
        accel_wrt_data = ser_word;
      end
      S_STATUS: begin
        accel_wrt_en   = 1'b1;
        accel_addr     = job_dst + 16'(DIGEST_WORDS);
        accel_wrt_data = status_word;
        done           = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy       = (state != S_IDLE);
  assign hash_start = hash_first;

endmodule

// File: doc/accel_dispatch.md
Name: accel_dispatch

Overview:
- Sits directly downstream of the CPU's accelerator-facing port.
- Consumes CPU memory-mapped writes (cpu_wrt_en/cpu_wrt_data/cpu_addr) as job commands.
- For each job, it fetches one 512-bit message block from data memory over the accel read port and hands it to a SHA-256 compression core.
- It then writes the 256-bit digest plus a status word back into data memory over the accel write port, where the CPU polls for it.

Parameters:
- MMIO_BASE, 16'hFF00, word address of the command window (BASE+0 = SRC, BASE+1 = DST, BASE+2 = GO).
- RD_LAT, 1, cycles from accel_addr driven to accel_rd_data valid (range 1..3).
- TIMEOUT_CYCLES, 1024, hash watchdog limit; used only when ACCEL_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous reset, active-high (asserted = 1); polarity fixed despite the name.
- cpu_wrt_en  in  1  CPU data-memory write strobe.
- cpu_wrt_data  in  32  CPU write data.
- cpu_addr  in  16  CPU write word address.
- accel_rd_data  in  512  data-memory block read at accel_addr.
- accel_addr  out  16  data-memory word address (fetch or writeback).
- accel_wrt_en  out  1  data-memory write strobe.
- accel_wrt_data  out  32  data-memory write data.
- hash_start  out  1  one-cycle pulse; hash_block is valid in the same cycle.
- hash_block  out  512  captured message block.
- hash_done  in  1  one-cycle pulse from the SHA core; hash_digest is valid in the same cycle.
- hash_digest  in  256  digest; [255:224] is word 0.
- busy  out  1  high from GO accept through STATUS write.
- done  out  1  one-cycle pulse in the STATUS cycle.

Behaviour:
- Reset: all outputs 0; src_reg = 0, dst_reg = 0, overrun = 0; FSM in IDLE. Reset mid-job aborts immediately with no further writes.
- MMIO decode (any state):
  - cpu_wrt_en && addr == BASE+0 → src_reg
  - cpu_wrt_en && addr == BASE+1 → dst_reg
  - cpu_wrt_en && addr == BASE+2 && data[0] → GO
- GO handling:
  - GO in IDLE is accepted on the next edge.
  - GO while busy is ignored and sets sticky overrun.
  - SRC/DST writes while busy update the registers but do not affect the running job, which uses its own latched copies.
- FSM: IDLE → FETCH → HASH → WRITE → STATUS → IDLE.
- FETCH:
  - accel_addr = job_src for RD_LAT cycles.
  - In the last cycle, capture accel_rd_data into hash_block.
- HASH:
  - Pulse hash_start in the first HASH cycle.
  - Wait for hash_done and capture hash_digest.
  - hash_done in any other state is ignored.
  - hash_done coincident with hash_start is legal and is accepted.
- WRITE:
  - 8 consecutive cycles, index i = 0..7.
  - accel_wrt_en = 1, accel_addr = job_dst + i, accel_wrt_data = digest word i.
- STATUS:
  - accel_wrt_en = 1, accel_addr = job_dst + 8, data = {29'b0, timeout, overrun, 1'b1}.
  - done = 1.
  - Overrun clears after this write.
- Latency, GO accept to done (no timeout): RD_LAT + H + 9 cycles, where H = hash cycles from hash_start to hash_done (≥1).
- Address arithmetic is modulo 2^16; dst = 16'hFFFA wraps the writes to 0xFFFA..0xFFFF, 0x0000..0x0002.
- accel_addr = 0 and accel_wrt_en = 0 in IDLE.
- Back-to-back jobs: a GO in the STATUS cycle counts as overrun. The first acceptable GO is in IDLE.

Optional Feature:
- Macro: ACCEL_TIMEOUT_EN.
- Defined:
  - A 16-bit counter runs in HASH.
  - Reaching TIMEOUT_CYCLES without hash_done skips WRITE, goes to STATUS with timeout = 1 (data bit2) and no digest writes.
  - A later stray hash_done is ignored.
- Undefined: no counter; HASH waits indefinitely; status bit2 is always 0.

Decomposition:
- Shared package accel_pkg holds:
  - the FSM state enum
  - MMIO offsets (OFF_SRC = 0, OFF_DST = 1, OFF_GO = 2)
  - status bit positions (ST_DONE = 0, ST_OVR = 1, ST_TO = 2)
  - DIGEST_WORDS = 8
- One natural sub-module, accel_digest_ser: latches the 256-bit digest and emits word i, with a 3-bit index counter and a last flag.

Test Plan:
- SRC = 0x0040, DST = 0x0100, GO; model returns digest 0x0011..ff (word i = 32'h1111_1111*i) after 5 cycles → writes to 0x0100..0x0107 in order, then 32'h1 to 0x0108; done pulses once; total 15 cycles (RD_LAT = 1).
- GO issued 3 cycles into HASH → job unaffected; status word = 32'h3; next job's status = 32'h1.
- DST = 0xFFFA → digest words land at 0xFFFA..0xFFFF, 0x0000, 0x0001; status at 0x0002.
- hash_done pulsed in IDLE and FETCH → no writes, no state change; job completes normally.
- Assert rst_n during WRITE index 3 → accel_wrt_en drops the next cycle, busy = 0, no status write; a new job then runs cleanly.
- With ACCEL_TIMEOUT_EN and TIMEOUT_CYCLES = 16, no hash_done → no digest writes; status 32'h5 written to DST+8 at cycle RD_LAT + 16 + 1.
